// File: rtl/kernel_zrle.sv
// kernel_zrle: zero-run-length encoder for fixed-size pixel frames.
// A zero run is emitted as a marker word 0 followed by the run length;
// non-zero pixels pass through unchanged. Runs saturate at MAX_RUN and are
// split, and any open run is flushed at the end of each frame.
// Optional frame terminator (two zero words after each frame) is enabled by
// defining the macro KERNEL_ZRLE_EOF_MARK_EN.
module kernel_zrle #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned PIXEL_COUNT = 1600,
    parameter int unsigned RUN_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] input_S1,
    input  logic                  avail_S1,
    output logic                  read_S1,
    output logic [DATA_WIDTH-1:0] output_S2,
    output logic                  write_S2,
    input  logic                  afull_S2
);

    localparam int unsigned PCNT_W = $clog2(PIXEL_COUNT + 1);
    localparam logic [RUN_WIDTH-1:0] MAX_RUN  = '1;
    localparam logic [PCNT_W-1:0]    LAST_PIX = PCNT_W'(PIXEL_COUNT);

    typedef enum logic [2:0] {
        S_READ,
        S_EVAL,
        S_EMIT_MARK,
        S_EMIT_COUNT,
        S_EMIT_LIT,
        S_FLUSH
`ifdef KERNEL_ZRLE_EOF_MARK_EN
        ,
        S_EOF_MARK0,
        S_EOF_MARK1
`endif
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   pix_q;
    logic [RUN_WIDTH-1:0]    run_q;
    logic [PCNT_W-1:0]       pcnt_q;
    logic                    lit_after_q;   // after a run count: 1 -> literal, 0 -> new marker

    logic                    emit_c;
    logic [DATA_WIDTH-1:0]   word_c;
    state_t                  eop_state_c;
    state_t                  flush_next_c;

    // Where to go once the current pixel is fully handled.
    always_comb begin
        eop_state_c = (pcnt_q == LAST_PIX) ? S_FLUSH : S_READ;
`ifdef KERNEL_ZRLE_EOF_MARK_EN
        flush_next_c = S_EOF_MARK0;
`else
        flush_next_c = S_READ;
`endif
    end

    // Output word selection and write request for the emitting states.
    always_comb begin
        emit_c = 1'b0;
        word_c = '0;
        case (state_q)
            S_EMIT_MARK: begin
                emit_c = 1'b1;
            end
            S_EMIT_COUNT: begin
                emit_c = 1'b1;
                word_c = DATA_WIDTH'(run_q);
            end
            S_EMIT_LIT: begin
                emit_c = 1'b1;
                word_c = pix_q;
            end
            S_FLUSH: begin
                emit_c = (run_q != '0);
                word_c = DATA_WIDTH'(run_q);
            end
`ifdef KERNEL_ZRLE_EOF_MARK_EN
            S_EOF_MARK0, S_EOF_MARK1: begin
                emit_c = 1'b1;
            end
`endif
            default: begin
                emit_c = 1'b0;
            end
        endcase
    end

    // Handshakes decode straight from state so a stall takes effect in the same cycle.
    assign write_S2  = !rst && emit_c && !afull_S2;
    assign output_S2 = write_S2 ? word_c : '0;
    assign read_S1   = !rst && (state_q == S_READ) && avail_S1;

    // Encoder FSM with run and pixel bookkeeping; every emit holds while afull_S2 is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_READ;
            pix_q       <= '0;
            run_q       <= '0;
            pcnt_q      <= '0;
            lit_after_q <= 1'b0;
        end else begin
            case (state_q)
                S_READ: begin
                    if (avail_S1) begin
                        pix_q   <= input_S1;
                        pcnt_q  <= pcnt_q + PCNT_W'(1);
                        state_q <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (pix_q == '0) begin
                        if (run_q == '0) begin
                            state_q <= S_EMIT_MARK;
                        end else if (run_q != MAX_RUN) begin
                            run_q   <= run_q + RUN_WIDTH'(1);
                            state_q <= eop_state_c;
                        end else begin
                            lit_after_q <= 1'b0;
                            state_q     <= S_EMIT_COUNT;
                        end
                    end else begin
                        if (run_q == '0) begin
                            state_q <= S_EMIT_LIT;
                        end else begin
                            lit_after_q <= 1'b1;
                            state_q     <= S_EMIT_COUNT;
                        end
                    end
                end
                S_EMIT_MARK: begin
                    if (!afull_S2) begin
                        run_q   <= RUN_WIDTH'(1);
                        state_q <= eop_state_c;
                    end
                end
                S_EMIT_COUNT: begin
                    if (!afull_S2) begin
                        run_q   <= '0;
                        state_q <= lit_after_q ? S_EMIT_LIT : S_EMIT_MARK;
                    end
                end
                S_EMIT_LIT: begin
                    if (!afull_S2) begin
                        state_q <= eop_state_c;
                    end
                end
                S_FLUSH: begin
                    if ((run_q == '0) || !afull_S2) begin
                        run_q   <= '0;
                        pcnt_q  <= '0;
                        state_q <= flush_next_c;
                    end
                end
`ifdef KERNEL_ZRLE_EOF_MARK_EN
                S_EOF_MARK0: begin
                    if (!afull_S2) begin
                        state_q <= S_EOF_MARK1;
                    end
                end
                S_EOF_MARK1: begin
                    if (!afull_S2) begin
                        state_q <= S_READ;
                    end
                end
`endif
                default: begin
                    state_q <= S_READ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_zrle.sv
// Self-checking bench for kernel_zrle (PIXEL_COUNT=8, RUN_WIDTH=2, DATA_WIDTH=16).
// Table of frames with hand-computed streams, plus stall and reset sequences.
module tb_kernel_zrle;

    logic        clk;
    logic        rst;
    logic [15:0] input_S1;
    logic        avail_S1;
    logic        read_S1;
    logic [15:0] output_S2;
    logic        write_S2;
    logic        afull_S2;

    int checks   = 0;
    int failures = 0;

    logic [15:0] got[$];
    int          rd_cyc[$];
    int          wr_cyc[$];
    int          cyc        = 0;
    int          overlap_bad = 0;
    int          afull_bad   = 0;

    typedef struct packed {
        logic [0:7][15:0]  pix;
        logic [0:13][15:0] exp;
        int unsigned       n;
    } vec_t;

    vec_t vecs[6];

    kernel_zrle #(
        .DATA_WIDTH (16),
        .PIXEL_COUNT(8),
        .RUN_WIDTH  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .input_S1 (input_S1),
        .avail_S1 (avail_S1),
        .read_S1  (read_S1),
        .output_S2(output_S2),
        .write_S2 (write_S2),
        .afull_S2 (afull_S2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output collector and protocol monitors, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (write_S2) begin
                got.push_back(output_S2);
                wr_cyc.push_back(cyc);
            end
            if (read_S1) rd_cyc.push_back(cyc);
            if (read_S1 && write_S2) overlap_bad++;
            if (write_S2 && afull_S2) afull_bad++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        got.delete();
        rd_cyc.delete();
        wr_cyc.delete();
    endtask

    // Offer n pixels of a frame, idling 'gap' cycles between them.
    task automatic send(input vec_t v, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            bit ok = 1'b0;
            input_S1 = v.pix[i];
            avail_S1 = 1'b1;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (read_S1) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                check("read_timeout", 0, 1);
                avail_S1 = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            avail_S1 = 1'b0;
            input_S1 = 16'hDEAD;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic check_stream(input string name, input vec_t v);
        check({name, "_len"}, got.size(), int'(v.n));
        for (int i = 0; i < int'(v.n) && i < got.size(); i++) begin
            check($sformatf("%s_w%0d", name, i), int'(got[i]), int'(v.exp[i]));
        end
    endtask

    task automatic stall_ctl();
        bit seen = 1'b0;
        int bad  = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (got.size() >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        check("stall_trigger", int'(seen), 1);
        @(posedge clk);
        #1;
        afull_S2 = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (write_S2) bad++;
        end
        check("stall_no_write", bad, 0);
        @(posedge clk);
        #1;
        afull_S2 = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        avail_S1 = 1'b0;
        afull_S2 = 1'b0;
        input_S1 = 16'd0;

        vecs[0].pix = {16'd5, 16'd0, 16'd0, 16'd0, 16'd7, 16'd0, 16'd0, 16'd9};
        vecs[0].exp = {16'd5, 16'd0, 16'd3, 16'd7, 16'd0, 16'd2, 16'd9,
                       16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        vecs[0].n   = 7;
        vecs[1].pix = {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        vecs[1].exp = {16'd0, 16'd3, 16'd0, 16'd3, 16'd0, 16'd2, 16'd0,
                       16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        vecs[1].n   = 6;
        vecs[2].pix = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd0, 16'd0};
        vecs[2].exp = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd0,
                       16'd2, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        vecs[2].n   = 8;
        vecs[3].pix = {16'hFFFF, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'h8000};
        vecs[3].exp = {16'hFFFF, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6,
                       16'h8000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        vecs[3].n   = 8;
        vecs[4].pix = {16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1};
        vecs[4].exp = {16'd0, 16'd1, 16'd1, 16'd0, 16'd1, 16'd1, 16'd0,
                       16'd1, 16'd1, 16'd0, 16'd1, 16'd1, 16'd0, 16'd0};
        vecs[4].n   = 12;
        vecs[5].pix = {16'd7, 16'd8, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        vecs[5].exp = {16'd7, 16'd8, 16'd0, 16'd3, 16'd0, 16'd3, 16'd0,
                       16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        vecs[5].n   = 6;
`ifdef KERNEL_ZRLE_EOF_MARK_EN
        // Terminator words are zeros, already present as padding after each stream.
        for (int v = 0; v < 6; v++) vecs[v].n = vecs[v].n + 2;
`endif

        // Reset state, with avail high to show reads are blocked.
        #3;
        avail_S1 = 1'b1;
        input_S1 = 16'd5;
        #1;
        check("rst_read", int'(read_S1), 0);
        check("rst_write", int'(write_S2), 0);
        check("rst_data", int'(output_S2), 0);
        repeat (2) @(negedge clk);
        check("rst_read_clk", int'(read_S1), 0);
        avail_S1 = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven frames.
        for (int v = 0; v < 6; v++) begin
            clear_logs();
            send(vecs[v], 8, v % 2);
            repeat (30) @(posedge clk);
            #1;
            check_stream($sformatf("vec%0d", v), vecs[v]);
            if (v == 3) begin
                check("lit_latency",
                      (rd_cyc.size() > 0 && wr_cyc.size() > 0) ? (wr_cyc[0] - rd_cyc[0]) : -1, 2);
            end
        end

        // Downstream stall after the second write.
        clear_logs();
        fork
            send(vecs[0], 8, 0);
            stall_ctl();
        join
        repeat (30) @(posedge clk);
        #1;
        check_stream("stall", vecs[0]);

        // Reset mid-run: three zeros accepted, open run must be dropped.
        clear_logs();
        send(vecs[1], 3, 0);
        check("pre_rst_len", got.size(), 1);
        #1;
        rst      = 1'b1;
        avail_S1 = 1'b1;
        #1;
        check("midrst_read", int'(read_S1), 0);
        check("midrst_write", int'(write_S2), 0);
        check("midrst_data", int'(output_S2), 0);
        repeat (2) @(negedge clk);
        avail_S1 = 1'b0;
        rst      = 1'b0;
        clear_logs();
        @(posedge clk);
        #1;
        send(vecs[0], 8, 0);
        repeat (30) @(posedge clk);
        #1;
        check_stream("post_rst", vecs[0]);

        check("no_rd_wr_overlap", overlap_bad, 0);
        check("no_write_in_afull", afull_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kernel_zrle.md
KERNEL_ZRLE -- requirements
Module: kernel_zrle

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, pixel/word width in bits.
REQ-002 SHALL have parameter PIXEL_COUNT, default 1600, pixels per frame (>=1).
REQ-003 SHALL have parameter RUN_WIDTH, default 16, run-counter width; RUN_WIDTH<=DATA_WIDTH; MAX_RUN = 2^RUN_WIDTH-1.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 input_S1  input  DATA_WIDTH  incoming pixel.
REQ-007 avail_S1  input  1  input_S1 is valid.
REQ-008 read_S1  output  1  pixel consumed this cycle.
REQ-009 output_S2  output  DATA_WIDTH  encoded word, valid only when write_S2=1.
REQ-010 write_S2  output  1  output_S2 written this cycle.
REQ-011 afull_S2  input  1  downstream almost full; no write while high.

Function
REQ-012 SHALL encode zero runs: first zero of a run emits marker word 0; run end emits run length zero-extended to DATA_WIDTH; non-zero pixels emit unchanged.
REQ-013 SHALL implement FSM states READ, EVAL, EMIT_MARK, EMIT_COUNT, EMIT_LIT, FLUSH (+ EOF_MARK0/EOF_MARK1 when REQ-028 enabled).
REQ-014 READ: read_S1 = avail_S1; on read, latch pixel, increment pixel counter, go to EVAL; else hold.
REQ-015 EVAL (1 cycle, no I/O): zero and not in run -> EMIT_MARK; zero, in run, run<MAX_RUN -> run+1, then end-of-pixel; zero, in run, run==MAX_RUN -> EMIT_COUNT then EMIT_MARK; non-zero not in run -> EMIT_LIT; non-zero in run -> EMIT_COUNT then EMIT_LIT.
REQ-016 EMIT_MARK writes 0 and sets run=1; EMIT_COUNT writes run and clears run; EMIT_LIT writes latched pixel.
REQ-017 Each EMIT/FLUSH state SHALL assert write_S2 only when afull_S2=0 and SHALL hold state, data and counters while afull_S2=1; no word lost or duplicated.
REQ-018 End-of-pixel: if pixel counter==PIXEL_COUNT go to FLUSH, else READ.
REQ-019 FLUSH: if run>0 write run (subject to REQ-017), clear run; clear pixel counter; return to READ. Runs never span frames.
REQ-020 Minimum latency: literal read in cycle N written in cycle N+2; read_S1 never asserted outside READ.
REQ-021 write_S2 and read_S1 SHALL never both be 1 in the same cycle.
REQ-022 Pixel counter width SHALL be clog2(PIXEL_COUNT+1); run counter width RUN_WIDTH, never wraps.

Reset
REQ-023 While rst=1: read_S1=0, write_S2=0, output_S2=0, state=READ, run=0, pixel counter=0, latched pixel=0.
REQ-024 rst asserted mid-frame or mid-emit SHALL abandon the frame without emitting pending words.
REQ-025 After rst release, first accepted pixel is pixel 0 of a new frame.
REQ-026 rst takes effect without a clock edge.

Configuration
REQ-027 Macro KERNEL_ZRLE_EOF_MARK_EN selects frame terminator.
REQ-028 Defined: after FLUSH, emit words 0 then 0 (marker with zero count, an illegal run) before returning to READ, each subject to REQ-017.
REQ-029 Undefined: no terminator; FLUSH returns directly to READ; EOF states absent.

Verification (PIXEL_COUNT=8, RUN_WIDTH=2, MAX_RUN=3, DATA_WIDTH=16)
REQ-030 Frame 5,0,0,0,7,0,0,9 -> stream 5,0,3,7,0,2,9.
REQ-031 Frame of eight zeros -> 0,3,0,3,0,2 (saturation split and flush).
REQ-032 Frame 1,2,3,4,5,6,0,0 -> 1,2,3,4,5,6,0,2 (run flushed at frame end).
REQ-033 REQ-030 input with afull_S2=1 for 10 cycles after second write -> write_S2=0 throughout stall; final stream identical.
REQ-034 rst pulsed after third zero of REQ-031 frame -> outputs 0 immediately; next frame 5,0,0,0,7,0,0,9 -> 5,0,3,7,0,2,9.
REQ-035 KERNEL_ZRLE_EOF_MARK_EN defined, REQ-030 input -> 5,0,3,7,0,2,9,0,0.
